// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle control path: sequencer states,
// trap causes and writeback-select codes agreed with ctrl_unit.
package rv_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5,
        ST_TRAP   = 3'd6
    } seq_state_e;

    localparam logic [1:0] TRAP_NONE    = 2'd0;
    localparam logic [1:0] TRAP_ILLEGAL = 2'd1;
    localparam logic [1:0] TRAP_IMEM_TO = 2'd2;
    localparam logic [1:0] TRAP_DMEM_TO = 2'd3;

    localparam logic [1:0] WB_SEL_ALU  = 2'b00;
    localparam logic [1:0] WB_SEL_PC   = 2'b01;
    localparam logic [1:0] WB_SEL_LD   = 2'b10;
    localparam logic [1:0] WB_SEL_NONE = 2'b11;

    // Loads and stores are the only instructions that visit MEM.
    function automatic logic needs_mem(input logic [1:0] wb_sel, input logic mem_wren);
        return (wb_sel == WB_SEL_LD) || mem_wren;
    endfunction

endpackage

// File: rtl/mem_watchdog.sv
// Wait-cycle counter shared by the imem and dmem handshakes; flags when the
// current cycle is the last one a request may wait without an ack.
module mem_watchdog #(
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_count_en,
    output logic o_expired_c
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYC);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_count_en) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // Counter holds the number of prior waiting cycles, so this cycle is wait #TIMEOUT_CYC.
    assign o_expired_c = (r_cnt == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/multicycle_seq.sv
// Multi-cycle instruction sequencer: walks FETCH/DECODE/EXEC/MEM/WB, turns
// decoder enables into one-shot strobes, runs memory handshakes and counters.
module multicycle_seq
    import rv_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 64,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_insn_vld,
    input  logic             i_rd_wren,
    input  logic             i_mem_wren,
    input  logic [1:0]       i_wb_sel,
    input  logic             i_halt,
    input  logic             i_imem_ack,
    input  logic             i_dmem_ack,
    output logic             o_imem_req,
    output logic             o_dmem_req,
    output logic             o_dmem_we,
    output logic             o_ir_en,
    output logic             o_pc_en,
    output logic             o_rf_wren,
    output logic             o_retire,
    output logic             o_halted,
    output logic             o_trap,
    output logic [1:0]       o_trap_cause,
    output logic [CNT_W-1:0] o_cycle_cnt,
    output logic [CNT_W-1:0] o_instret_cnt
);

    seq_state_e       r_state;
    seq_state_e       w_state_nxt;
    logic [1:0]       r_cause;
    logic [1:0]       w_cause_nxt;
    logic [CNT_W-1:0] r_cycle_cnt;
    logic [CNT_W-1:0] r_instret_cnt;
    logic             w_waiting;
    logic             w_expired;

    // A request is waiting whenever it is up and this cycle brings no ack.
    assign w_waiting = ((r_state == ST_FETCH) && !i_imem_ack) ||
                       ((r_state == ST_MEM)   && !i_dmem_ack);

    mem_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_clear     (!w_waiting),
        .i_count_en  (w_waiting),
        .o_expired_c (w_expired)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= ST_FETCH;
            r_cause       <= TRAP_NONE;
            r_cycle_cnt   <= '0;
            r_instret_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cause     <= w_cause_nxt;
            r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
            if (o_retire) begin
                r_instret_cnt <= r_instret_cnt + CNT_W'(1);
            end
        end
    end

    // Next state and strobes; everything is held low while reset is asserted.
    always_comb begin
        w_state_nxt = r_state;
        w_cause_nxt = r_cause;
        o_imem_req  = 1'b0;
        o_dmem_req  = 1'b0;
        o_dmem_we   = 1'b0;
        o_ir_en     = 1'b0;
        o_pc_en     = 1'b0;
        o_rf_wren   = 1'b0;
        o_retire    = 1'b0;
        o_halted    = 1'b0;
        o_trap      = 1'b0;
        if (!i_reset) begin
            case (r_state)
                ST_FETCH: begin
                    o_imem_req = 1'b1;
                    if (i_imem_ack) begin
                        o_ir_en     = 1'b1;
                        w_state_nxt = ST_DECODE;
                    end else if (w_expired) begin
                        w_state_nxt = ST_TRAP;
                        w_cause_nxt = TRAP_IMEM_TO;
                    end
                end
                ST_DECODE: begin
                    if (i_insn_vld) begin
                        w_state_nxt = ST_EXEC;
                    end else begin
                        w_state_nxt = ST_TRAP;
                        w_cause_nxt = TRAP_ILLEGAL;
                    end
                end
                ST_EXEC: begin
                    w_state_nxt = needs_mem(i_wb_sel, i_mem_wren) ? ST_MEM : ST_WB;
                end
                ST_MEM: begin
                    o_dmem_req = 1'b1;
                    o_dmem_we  = i_mem_wren;
                    if (i_dmem_ack) begin
                        if (i_mem_wren) begin
                            o_pc_en     = 1'b1;
                            o_retire    = 1'b1;
                            w_state_nxt = i_halt ? ST_HALT : ST_FETCH;
                        end else begin
                            w_state_nxt = ST_WB;
                        end
                    end else if (w_expired) begin
                        w_state_nxt = ST_TRAP;
                        w_cause_nxt = TRAP_DMEM_TO;
                    end
                end
                ST_WB: begin
                    o_rf_wren   = i_rd_wren;
                    o_pc_en     = 1'b1;
                    o_retire    = 1'b1;
                    w_state_nxt = i_halt ? ST_HALT : ST_FETCH;
                end
                ST_HALT: begin
                    o_halted = 1'b1;
                    if (!i_halt) begin
                        w_state_nxt = ST_FETCH;
                    end
                end
                ST_TRAP: begin
                    o_trap = 1'b1;
                end
                default: begin
                    w_state_nxt = ST_FETCH;
                end
            endcase
        end
    end

    assign o_trap_cause  = i_reset ? TRAP_NONE : r_cause;
    assign o_cycle_cnt   = r_cycle_cnt;
    assign o_instret_cnt = r_instret_cnt;

endmodule
